// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider producing {remainder, quotient} for DIV/DIVU.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
  state_t state, state_n;
  logic sgn, sgn_n, s1, s1_n, s2, s2_n, rdy_n;
  logic [DATA_W-1:0] dvd, dvd_n, dvs, dvs_n, rem, rem_n, rem_i, quo_i;
  logic [DATA_W:0] sh, trial;
  logic [CW-1:0] cnt, cnt_n;
  logic [2*DATA_W-1:0] res_n;
  // One restoring step: the quotient bit is shifted into the vacated dividend LSB.
  always_comb begin
    sh = {rem, dvd[DATA_W-1]};
    trial = sh - {1'b0, dvs};
    rem_i = trial[DATA_W] ? sh[DATA_W-1:0] : trial[DATA_W-1:0];
    quo_i = {dvd[DATA_W-2:0], ~trial[DATA_W]};
  end
  always_comb begin
    state_n = state;
    sgn_n = sgn;
    s1_n = s1;
    s2_n = s2;
    dvd_n = dvd;
    dvs_n = dvs;
    rem_n = rem;
    cnt_n = cnt;
    res_n = result_o;
    rdy_n = ready_o;
    case (state)
      FREE: begin
        res_n = '0;
        rdy_n = 1'b0;
        if (start_i && !annul_i) begin
          sgn_n = signed_div_i;
          s1_n = signed_div_i & opdata1_i[DATA_W-1];
          s2_n = signed_div_i & opdata2_i[DATA_W-1];
          dvd_n = s1_n ? -opdata1_i : opdata1_i;
          dvs_n = s2_n ? -opdata2_i : opdata2_i;
          rem_n = '0;
          cnt_n = '0;
          state_n = (opdata2_i == '0) ? BYZERO : ON;
        end
      end
      BYZERO: begin
        state_n = annul_i ? FREE : END;
        res_n = '0;
        rdy_n = !annul_i;
      end
      ON: begin
        if (annul_i) begin
          state_n = FREE;
          res_n = '0;
          rdy_n = 1'b0;
        end else begin
          rem_n = rem_i;
          dvd_n = quo_i;
          cnt_n = cnt + 1'b1;
          if (cnt == LAST) begin
            state_n = END;
            rdy_n = 1'b1;
            res_n = {(sgn & s1) ? -rem_i : rem_i, (sgn & (s1 ^ s2)) ? -quo_i : quo_i};
          end
        end
      end
      END: begin
        if (annul_i || !start_i) begin
          state_n = FREE;
          res_n = '0;
          rdy_n = 1'b0;
        end
      end
      default: state_n = FREE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FREE;
      sgn <= 1'b0;
      s1 <= 1'b0;
      s2 <= 1'b0;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      cnt <= '0;
      result_o <= '0;
      ready_o <= 1'b0;
    end else begin
      state <= state_n;
      sgn <= sgn_n;
      s1 <= s1_n;
      s2 <= s2_n;
      dvd <= dvd_n;
      dvs <= dvs_n;
      rem <= rem_n;
      cnt <= cnt_n;
      result_o <= res_n;
      ready_o <= rdy_n;
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and random DIV/DIVU checks against an arithmetic reference model.
module tb_div_unit;
  logic clk = 1'b0, rst = 1'b1, sg = 1'b0, start = 1'b0, annul = 1'b0, ready, seen;
  logic [31:0] op1 = '0, op2 = '0, ra, rb;
  logic [63:0] result;
  int checks = 0, errors = 0;
  div_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(sg), .opdata1_i(op1), .opdata2_i(op2),
    .start_i(start), .annul_i(annul), .result_o(result), .ready_o(ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Reference: wide-integer division, truncation toward zero; zero divisor yields 0.
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    if (b == '0) return '0;
    if (s) begin
      longint x = longint'($signed(a));
      longint y = longint'($signed(b));
      longint q = x / y;
      longint r = x % y;
      return {r[31:0], q[31:0]};
    end else begin
      longint unsigned x = {32'd0, a};
      longint unsigned y = {32'd0, b};
      longint unsigned q = x / y;
      longint unsigned r = x % y;
      return {r[31:0], q[31:0]};
    end
  endfunction
  task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [63:0] exp;
    exp = model(s, a, b);
    @(posedge clk); #1;
    sg = s; op1 = a; op2 = b; start = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        op1 = $urandom; op2 = $urandom; sg = 1'($urandom);
      end
    end while (!ready && n < 40);
    chk("latency", 64'(n), (b == '0) ? 64'd2 : 64'd33);
    chk("result", result, exp);
    repeat (2) @(posedge clk);
    #1;
    chk("hold_ready", {63'd0, ready}, 64'd1);
    chk("hold_result", result, exp);
    start = 1'b0;
    @(posedge clk); #1;
    chk("drop_ready", {63'd0, ready}, 64'd0);
    chk("drop_result", result, 64'd0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {63'd0, ready}, 64'd0);
    chk("reset_result", result, 64'd0);
    rst = 1'b0;
    run(1'b0, 32'd100, 32'd7);
    chk("divu_100_7", model(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
    run(1'b1, -32'sd7, 32'd2);
    run(1'b1, 32'd7, -32'sd2);
    run(1'b1, -32'sd7, -32'sd2);
    run(1'b0, 32'hFFFF_FFF9, 32'd2);
    run(1'b1, 32'd12345, 32'd0);
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run(1'b0, 32'hFFFF_FFFF, 32'd1);
    run(1'b1, 32'd0, 32'd5);
    // annul on the 10th ON cycle
    @(posedge clk); #1;
    sg = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    annul = 1'b0;
    chk("annul_ready", {63'd0, ready}, 64'd0);
    chk("annul_result", result, 64'd0);
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      seen |= ready;
    end
    chk("annul_never_ready", {63'd0, seen}, 64'd0);
    run(1'b0, 32'd50, 32'd5);
    // annul in FREE blocks a start
    @(posedge clk); #1;
    sg = 1'b0; op1 = 32'd9; op2 = 32'd2; start = 1'b1; annul = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    seen = 1'b0;
    repeat (36) begin
      @(posedge clk); #1;
      seen |= ready;
    end
    chk("free_annul_blocks", {63'd0, seen}, 64'd0);
    // reset mid-division at iteration 20
    @(posedge clk); #1;
    sg = 1'b1; op1 = 32'd77777; op2 = 32'd13; start = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_ready", {63'd0, ready}, 64'd0);
    chk("midrst_result", result, 64'd0);
    seen = 1'b0;
    repeat (35) begin
      @(posedge clk); #1;
      seen |= ready;
    end
    chk("midrst_idle", {63'd0, seen}, 64'd0);
    run(1'b1, -32'sd1000, 32'd33);
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) rb = rb >> $urandom_range(31, 16);
      if (i % 8 == 7) rb = '0;
      run(1'($urandom), ra, rb);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle iterative divider that produces the HI/LO writeback pair for DIV/DIVU.
- Sits in the EX stage. It accepts operands through a start/ready handshake and returns {remainder, quotient}. EX forwards these as hi_i = result_o[63:32] and lo_i = result_o[31:0], with we asserted.
- The pipeline stalls EX while the unit is busy.
- Restoring shift-subtract algorithm, one quotient bit per cycle.

Parameters:
- DATA_W, 32, operand width; result_o is 2*DATA_W. All default-value numbers below assume DATA_W = 32.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i
- opdata1_i  input  DATA_W  dividend; sampled with start_i
- opdata2_i  input  DATA_W  divisor; sampled with start_i
- start_i  input  1  request; held high by EX until ready_o is seen
- annul_i  input  1  cancel in-flight division (flush/exception)
- result_o  output  2*DATA_W  {remainder, quotient}; valid only while ready_o = 1
- ready_o  output  1  result valid

Behaviour:
- Reset: on a rising edge with rst = 1, state = FREE, ready_o = 0, result_o = 0, iteration counter = 0, internal operand registers = 0. Reset overrides every other input in any state, including mid-division.
- States: FREE, BYZERO, ON, END. Clock is clk; reset is synchronous and active-high.
- FREE, start_i = 1, annul_i = 0:
  - Latch signed_div_i.
  - If the divisor is 0, go to BYZERO.
  - Otherwise go to ON. In signed mode, latch |dividend| and |divisor| (two's-complement negate when the MSB is 1) and latch both operand sign bits; in unsigned mode, latch the operands as-is.
  - Set partial remainder = 0 and counter = 0.
- FREE otherwise: stay; ready_o = 0, result_o = 0.
- BYZERO: next edge goes to END with result_o = 0 and ready_o = 1. No exception is raised; HI/LO are written with 0.
- ON, annul_i = 1: next edge goes to FREE, ready_o = 0, result_o = 0. The partial result is discarded.
- ON, annul_i = 0, one iteration per edge:
  - Shift {rem, dividend} left by 1.
  - Trial = rem − divisor, computed at DATA_W+1 bits.
  - If the trial is non-negative, rem = trial and the quotient LSB = 1; else the quotient LSB = 0.
  - Counter increments.
- ON, 32nd iteration edge (counter = DATA_W−1 before the edge):
  - Apply the final correction and go to END with ready_o = 1.
  - Signed mode: quotient negated iff the two latched sign bits differ; remainder negated iff the dividend was negative.
  - Unsigned mode: no correction.
- Latency:
  - Nonzero divisor: start sampled at edge E0, ready_o = 1 after edge E32.
  - Zero divisor: ready_o = 1 after edge E1.
- END:
  - result_o and ready_o are held stable.
  - If start_i = 0 at an edge, go to FREE with ready_o = 0 and result_o = 0.
  - If start_i = 1, stay in END. No new division starts until start_i has dropped for at least one edge.
- annul_i in BYZERO or END: go to FREE, ready_o = 0, result_o = 0. annul_i in FREE blocks a start on that edge.
- Overflow (signed): 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. No trap.
- Operand inputs may change after the start edge without affecting the division in progress.

Test Plan:
- Unsigned divide: DIVU 100 / 7 -> ready_o high exactly 32 edges after the start edge; result_o = {0x00000002, 0x0000000E}; ready_o and result_o held while start_i = 1; both return to 0 one edge after start_i drops.
- Signed sign rules:
  - DIV −7 / 2 -> {0xFFFFFFFF, 0xFFFFFFFD}.
  - DIV 7 / −2 -> {0x00000001, 0xFFFFFFFD}.
  - DIV −7 / −2 -> {0xFFFFFFFF, 0x00000003}.
  - DIVU 0xFFFFFFF9 / 2 -> {0x00000001, 0x7FFFFFFC}.
- Divide by zero: DIV 12345 / 0 -> ready_o high after 2 edges; result_o = 0.
- Signed overflow and trivial cases:
  - DIV 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
  - DIVU 0xFFFFFFFF / 1 -> {0, 0xFFFFFFFF}.
  - DIV 0 / 5 -> 0.
- Annul and restart: annul_i pulsed on the 10th ON cycle -> FREE next edge, ready_o never asserts. An immediately following DIVU 50 / 5 completes in 32 edges with result {0, 10}.
- Reset mid-operation: rst asserted for 1 edge at iteration 20 -> state FREE, result_o = 0, ready_o = 0. A subsequent new division completes correctly.
